// File: rtl/uart_controller.sv
// Sequencer that launches sub-FSMs 0..4 in order, with a fixed-length idle gap
// after each UART transfer and a closing path taken once no more items remain.
module uart_controller #(
    parameter int CNT_W    = 13,
    parameter int LAST_POS = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       noMoreDone,
    input  logic       doneFSM0,
    input  logic       doneFSM1,
    input  logic       doneFSM2,
    input  logic       doneFSM3,
    input  logic       doneFSM4,
    output logic       beginFSM0,
    output logic       beginFSM1,
    output logic       beginFSM2,
    output logic       beginFSM3,
    output logic       beginFSM4,
    output logic [2:0] uartsel,
    output logic [4:0] arraypos,
    output logic       done
);

    typedef enum logic [4:0] {
        INIT, START_FSM0, WAIT_FSM0, WAIT_UART0,
        START_FSM1, WAIT_FSM1, WAIT_UART1,
        START_FSM2, WAIT_FSM2,
        START_FSM3, WAIT_FSM3, WAIT_UART3,
        START_FSM4, WAIT_FSM4, LOOPBACK,
        START_FSM3_2, WAIT_FSM3_2, WAIT_UART3_2,
        START_FSM4_2, WAIT_FSM4_2, WAIT_UART4_2,
        FINISH
    } state_t;

    localparam logic [CNT_W-1:0] GAP_END = '1;
    localparam logic [4:0]       LAST    = 5'(LAST_POS);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [4:0]       r_arraypos;
    logic [4:0]       w_nextArraypos;
    logic [4:0]       r_begin;
    logic [4:0]       w_begin;
    logic [2:0]       r_uartsel;
    logic [2:0]       w_uartsel;
    logic             r_done;
    logic             w_gap;
    logic             w_gapEnd;

    always_comb begin
        w_gap = (r_state == WAIT_UART0)   || (r_state == WAIT_UART1) ||
                (r_state == WAIT_UART3)   || (r_state == LOOPBACK)   ||
                (r_state == WAIT_UART3_2) || (r_state == WAIT_UART4_2);
        w_gapEnd = w_gap && (r_count == GAP_END);
    end

    always_comb begin
        w_next         = r_state;
        w_nextArraypos = r_arraypos;
        case (r_state)
            INIT:         if (start)    w_next = START_FSM0;
            START_FSM0:                 w_next = WAIT_FSM0;
            WAIT_FSM0:    if (doneFSM0) w_next = WAIT_UART0;
            WAIT_UART0:   if (w_gapEnd) w_next = START_FSM1;
            START_FSM1:                 w_next = WAIT_FSM1;
            WAIT_FSM1:    if (doneFSM1) w_next = WAIT_UART1;
            WAIT_UART1:   if (w_gapEnd) w_next = START_FSM2;
            START_FSM2:                 w_next = WAIT_FSM2;
            WAIT_FSM2: begin
                if (noMoreDone)    w_next = START_FSM3_2;
                else if (doneFSM2) w_next = START_FSM3;
            end
            START_FSM3:                 w_next = WAIT_FSM3;
            WAIT_FSM3:    if (doneFSM3) w_next = WAIT_UART3;
            // The last array slot hands off to FSM4 and rewinds the index
            WAIT_UART3: begin
                if (w_gapEnd) begin
                    if (r_arraypos == LAST) begin
                        w_next         = START_FSM4;
                        w_nextArraypos = 5'd0;
                    end else begin
                        w_next         = START_FSM1;
                        w_nextArraypos = r_arraypos + 5'd1;
                    end
                end
            end
            START_FSM4:                   w_next = WAIT_FSM4;
            WAIT_FSM4:    if (doneFSM4)   w_next = LOOPBACK;
            LOOPBACK:     if (w_gapEnd)   w_next = START_FSM1;
            START_FSM3_2:                 w_next = WAIT_FSM3_2;
            WAIT_FSM3_2:  if (doneFSM3)   w_next = WAIT_UART3_2;
            WAIT_UART3_2: if (w_gapEnd)   w_next = START_FSM4_2;
            START_FSM4_2:                 w_next = WAIT_FSM4_2;
            WAIT_FSM4_2:  if (doneFSM4)   w_next = WAIT_UART4_2;
            WAIT_UART4_2: if (w_gapEnd)   w_next = FINISH;
            FINISH:                       w_next = FINISH;
            default:                      w_next = INIT;
        endcase
    end

    // Outputs are decoded from the next state so the registers track the state
    always_comb begin
        w_begin   = 5'b00000;
        w_uartsel = 3'd0;
        case (w_next)
            START_FSM0:                             w_begin = 5'b00001;
            START_FSM1:                             w_begin = 5'b00010;
            START_FSM2:                             w_begin = 5'b00100;
            START_FSM3, START_FSM3_2:               w_begin = 5'b01000;
            START_FSM4, START_FSM4_2:               w_begin = 5'b10000;
            default:                                w_begin = 5'b00000;
        endcase
        case (w_next)
            START_FSM1, WAIT_FSM1, WAIT_UART1:      w_uartsel = 3'd1;
            START_FSM2, WAIT_FSM2:                  w_uartsel = 3'd2;
            START_FSM3, WAIT_FSM3, WAIT_UART3,
            START_FSM3_2, WAIT_FSM3_2, WAIT_UART3_2: w_uartsel = 3'd3;
            START_FSM4, WAIT_FSM4, LOOPBACK,
            START_FSM4_2, WAIT_FSM4_2, WAIT_UART4_2,
            FINISH:                                 w_uartsel = 3'd4;
            default:                                w_uartsel = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= INIT;
            r_count    <= '0;
            r_arraypos <= 5'd0;
            r_begin    <= 5'b00000;
            r_uartsel  <= 3'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_count    <= (w_gap && !w_gapEnd) ? r_count + 1'b1 : '0;
            r_arraypos <= w_nextArraypos;
            r_begin    <= w_begin;
            r_uartsel  <= w_uartsel;
            r_done     <= (w_next == FINISH);
        end
    end

    assign beginFSM0 = r_begin[0];
    assign beginFSM1 = r_begin[1];
    assign beginFSM2 = r_begin[2];
    assign beginFSM3 = r_begin[3];
    assign beginFSM4 = r_begin[4];
    assign uartsel   = r_uartsel;
    assign arraypos  = r_arraypos;
    assign done      = r_done;

endmodule

// File: tb/tb_uart_controller.sv
// Directed bench for uart_controller using a narrowed gap counter so the full
// 20-slot loop fits in a short run; expected outputs flow through a queue.
module tb_uart_controller;

    localparam int CNT_W    = 6;
    localparam int LAST_POS = 19;
    localparam int GAP      = 1 << CNT_W;

    logic       clk;
    logic       reset;
    logic       start;
    logic       noMoreDone;
    logic       doneFSM0, doneFSM1, doneFSM2, doneFSM3, doneFSM4;
    logic       beginFSM0, beginFSM1, beginFSM2, beginFSM3, beginFSM4;
    logic [2:0] uartsel;
    logic [4:0] arraypos;
    logic       done;

    logic [13:0] expQ[$];
    int          compared  = 0;
    int          failCount = 0;

    uart_controller #(.CNT_W(CNT_W), .LAST_POS(LAST_POS)) dut (
        .clk(clk), .reset(reset), .start(start), .noMoreDone(noMoreDone),
        .doneFSM0(doneFSM0), .doneFSM1(doneFSM1), .doneFSM2(doneFSM2),
        .doneFSM3(doneFSM3), .doneFSM4(doneFSM4),
        .beginFSM0(beginFSM0), .beginFSM1(beginFSM1), .beginFSM2(beginFSM2),
        .beginFSM3(beginFSM3), .beginFSM4(beginFSM4),
        .uartsel(uartsel), .arraypos(arraypos), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic nmd,
                                 input logic [4:0] dn);
        reset      = rst;
        start      = st;
        noMoreDone = nmd;
        {doneFSM4, doneFSM3, doneFSM2, doneFSM1, doneFSM0} = dn;
    endtask

    task automatic checkOutput(input string tag);
        logic [13:0] expv;
        logic [13:0] obs;
        expv = expQ.pop_front();
        obs  = {uartsel, beginFSM4, beginFSM3, beginFSM2, beginFSM1, beginFSM0,
                arraypos, done};
        compared++;
        assert (obs === expv) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h (uartsel,begin[4:0],arraypos,done)",
                   tag, obs, expv);
        end
    endtask

    task automatic expectStep(input string tag, input logic [2:0] us,
                              input logic [4:0] beg, input logic [4:0] ap,
                              input logic dn);
        expQ.push_back({us, beg, ap, dn});
        tick();
        checkOutput(tag);
    endtask

    // Caller has just observed gap entry; this checks the last in-gap cycle
    task automatic gapHold(input string tag, input logic [2:0] us, input logic [4:0] ap);
        repeat (GAP - 2) tick();
        expectStep(tag, us, 5'b00000, ap, 1'b0);
    endtask

    initial begin
        $display("[TB] uart_controller bench, gap length %0d cycles", GAP);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000);
        tick();
        tick();
        expectStep("resetInit", 3'd0, 5'b00000, 5'd0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 5'b00000);
        expectStep("startFSM0", 3'd0, 5'b00001, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'b00000);
        expectStep("resetFromStart0", 3'd0, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'b00000);
        expectStep("restartFSM0", 3'd0, 5'b00001, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000);
        expectStep("waitFSM0", 3'd0, 5'b00000, 5'd0, 1'b0);
        expectStep("waitFSM0Hold", 3'd0, 5'b00000, 5'd0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00001);
        expectStep("waituart0", 3'd0, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000);
        gapHold("waituart0Gap", 3'd0, 5'd0);
        expectStep("startFSM1", 3'd1, 5'b00010, 5'd0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 5'b01110);
        for (int k = 0; k <= LAST_POS; k++) begin
            expectStep("waitFSM1", 3'd1, 5'b00000, 5'(k), 1'b0);
            expectStep("waituart1", 3'd1, 5'b00000, 5'(k), 1'b0);
            gapHold("waituart1Gap", 3'd1, 5'(k));
            expectStep("startFSM2", 3'd2, 5'b00100, 5'(k), 1'b0);
            expectStep("waitFSM2", 3'd2, 5'b00000, 5'(k), 1'b0);
            expectStep("startFSM3", 3'd3, 5'b01000, 5'(k), 1'b0);
            expectStep("waitFSM3", 3'd3, 5'b00000, 5'(k), 1'b0);
            expectStep("waituart3", 3'd3, 5'b00000, 5'(k), 1'b0);
            gapHold("waituart3Gap", 3'd3, 5'(k));
            if (k < LAST_POS)
                expectStep("loopStartFSM1", 3'd1, 5'b00010, 5'(k + 1), 1'b0);
            else
                expectStep("startFSM4", 3'd4, 5'b10000, 5'd0, 1'b0);
        end

        expectStep("waitFSM4", 3'd4, 5'b00000, 5'd0, 1'b0);
        expectStep("waitFSM4Hold", 3'd4, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b11110);
        expectStep("loopback", 3'd4, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b01110);
        gapHold("loopbackGap", 3'd4, 5'd0);
        expectStep("loopbackToFSM1", 3'd1, 5'b00010, 5'd0, 1'b0);

        expectStep("waitFSM1b", 3'd1, 5'b00000, 5'd0, 1'b0);
        expectStep("waituart1b", 3'd1, 5'b00000, 5'd0, 1'b0);
        gapHold("waituart1bGap", 3'd1, 5'd0);
        expectStep("startFSM2b", 3'd2, 5'b00100, 5'd0, 1'b0);
        expectStep("waitFSM2b", 3'd2, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'b01110);
        expectStep("startFSM3_2", 3'd3, 5'b01000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b01110);
        expectStep("waitFSM3_2", 3'd3, 5'b00000, 5'd0, 1'b0);
        expectStep("waituart3_2", 3'd3, 5'b00000, 5'd0, 1'b0);
        gapHold("waituart3_2Gap", 3'd3, 5'd0);
        expectStep("startFSM4_2", 3'd4, 5'b10000, 5'd0, 1'b0);
        expectStep("waitFSM4_2", 3'd4, 5'b00000, 5'd0, 1'b0);
        expectStep("waitFSM4_2Hold", 3'd4, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b10000);
        expectStep("waituart4_2", 3'd4, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000);
        gapHold("waituart4_2Gap", 3'd4, 5'd0);
        expectStep("finish", 3'd4, 5'b00000, 5'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 5'b11111);
        expectStep("finishHold1", 3'd4, 5'b00000, 5'd0, 1'b1);
        expectStep("finishHold2", 3'd4, 5'b00000, 5'd0, 1'b1);
        expectStep("finishHold3", 3'd4, 5'b00000, 5'd0, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000);
        expectStep("resetFromFinish", 3'd0, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'b00000);
        expectStep("startFSM0c", 3'd0, 5'b00001, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000);
        expectStep("waitFSM0c", 3'd0, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00001);
        expectStep("waituart0c", 3'd0, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000);
        repeat (10) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'b00000);
        expectStep("resetMidGap", 3'd0, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000);
        expectStep("initIdle", 3'd0, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'b00000);
        expectStep("startFSM0d", 3'd0, 5'b00001, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00001);
        expectStep("waitFSM0d", 3'd0, 5'b00000, 5'd0, 1'b0);
        expectStep("waituart0d", 3'd0, 5'b00000, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000);
        gapHold("waituart0dGap", 3'd0, 5'd0);
        expectStep("startFSM1d", 3'd1, 5'b00010, 5'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failCount);
        $finish;
    end

endmodule
